cl_sde_vgg_result_packer: RTL and testbench

//  Downstream of the VGG classifier stage in the SDE stream path. Takes one result

---
 rtl/cl_sde_pkg.sv | 10 +
 rtl/cl_sde_argmax_seq.sv | 43 ++++
 rtl/cl_sde_vgg_result_packer.sv | 92 +++++++++
 tb/tb_cl_sde_vgg_result_packer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/cl_sde_pkg.sv
// cl_sde_pkg: shared types for the SDE result packer (record layout, FSM states)
package cl_sde_pkg;
   localparam int REC_W = 32;
   typedef struct packed {
      logic [15:0] logit;
      logic [11:0] seq;
      logic [3:0]  cls;
   } sde_rec_t;
   typedef enum logic [1:0] {IDLE, SCAN, STORE, EMIT} packer_state_e;
endpackage

// File: rtl/cl_sde_argmax_seq.sv
// cl_sde_argmax_seq: sequential signed argmax, one class compared per cycle
module cl_sde_argmax_seq #(
   parameter int NUM_CLASS = 10,
   parameter int LOGIT_W   = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic [NUM_CLASS*LOGIT_W-1:0] logits,
   output logic                         done,
   output logic [3:0]                   idx,
   output logic signed [LOGIT_W-1:0]    max_logit
);
   logic [NUM_CLASS*LOGIT_W-1:0] data_q;
   logic [3:0] i_q;
   logic busy_q;
   logic signed [LOGIT_W-1:0] cur;
   assign cur = data_q[i_q*LOGIT_W +: LOGIT_W];
   // done marks the final compare; idx/max_logit hold the result from the next cycle
   assign done = busy_q && i_q == 4'(NUM_CLASS-1);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_q    <= '0;
         i_q       <= '0;
         busy_q    <= 1'b0;
         idx       <= '0;
         max_logit <= '0;
      end else if (start) begin
         data_q    <= logits;
         i_q       <= 4'd1;
         busy_q    <= 1'b1;
         idx       <= '0;
         max_logit <= logits[LOGIT_W-1:0];
      end else if (busy_q) begin
         if (cur > max_logit) begin
            max_logit <= cur;
            idx       <= i_q;
         end
         i_q    <= done ? i_q : i_q + 4'd1;
         busy_q <= !done;
      end
   end
endmodule

// File: rtl/cl_sde_vgg_result_packer.sv
// cl_sde_vgg_result_packer: argmax per VGG result beat, packs 32-bit records
// into 512-bit AXI-stream beats, flushing on full or idle timeout.
module cl_sde_vgg_result_packer
   import cl_sde_pkg::*;
#(
   parameter int NUM_CLASS = 10,
   parameter int LOGIT_W   = 16,
   parameter int PACK_N    = 16,
   parameter int SEQ_W     = 12,
   parameter int TO_W      = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [TO_W-1:0]              cfg_flush_to,
   input  logic                         cfg_clear,
   input  logic                         s_valid,
   input  logic [NUM_CLASS*LOGIT_W-1:0] s_data,
   output logic                         s_ready,
   output logic                         m_valid,
   output logic [511:0]                 m_data,
   output logic [63:0]                  m_keep,
   output logic [63:0]                  m_user,
   output logic                         m_last,
   input  logic                         m_ready,
   output logic [31:0]                  img_count
);
   packer_state_e state_q, state_d;
   logic [4:0] count_q;
   logic [SEQ_W-1:0] seq_q;
   logic [TO_W-1:0] idle_q;
   logic [511:0] rec_buf_q;
   logic clr_pend_q, accept, clr_now, to_fire, am_done;
   logic [3:0] am_idx;
   logic signed [LOGIT_W-1:0] am_max;
   logic [6:0] sh;
   sde_rec_t rec;
   cl_sde_argmax_seq #(.NUM_CLASS(NUM_CLASS), .LOGIT_W(LOGIT_W)) u_argmax (
      .clk(clk), .rst_n(rst_n), .start(accept), .logits(s_data),
      .done(am_done), .idx(am_idx), .max_logit(am_max)
   );
   assign s_ready = state_q == IDLE;
   assign accept  = s_valid && s_ready;
   assign m_valid = state_q == EMIT;
   assign m_last  = m_valid;
   // a clear raised outside IDLE waits in clr_pend_q until IDLE is re-entered
   assign clr_now = s_ready && (cfg_clear || clr_pend_q);
   assign to_fire = s_ready && !accept && !clr_now && count_q != 5'd0 &&
                    cfg_flush_to != '0 && idle_q + 1'b1 == cfg_flush_to;
   assign rec     = '{logit: 16'(am_max), seq: 12'(seq_q), cls: am_idx};
   assign sh      = 7'd64 - {count_q, 2'b00};
   assign m_data  = m_valid ? rec_buf_q : '0;
   assign m_keep  = m_valid ? {64{1'b1}} >> sh : '0;
   assign m_user  = m_valid ? {56'd0, 3'd0, count_q} : '0;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    state_d = accept ? SCAN : to_fire ? EMIT : IDLE;
         SCAN:    state_d = am_done ? STORE : SCAN;
         STORE:   state_d = count_q + 5'd1 == 5'(PACK_N) ? EMIT : IDLE;
         default: state_d = m_ready ? IDLE : EMIT;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         count_q    <= '0;
         seq_q      <= '0;
         idle_q     <= '0;
         rec_buf_q  <= '0;
         clr_pend_q <= 1'b0;
         img_count  <= '0;
      end else begin
         state_q    <= state_d;
         clr_pend_q <= s_ready ? 1'b0 : clr_pend_q || cfg_clear;
         idle_q     <= (s_ready && !accept && !clr_now && !to_fire && count_q != 5'd0 &&
                        cfg_flush_to != '0) ? idle_q + 1'b1 : '0;
         if (clr_now) begin
            count_q   <= '0;
            seq_q     <= '0;
            rec_buf_q <= '0;
         end else if (state_q == STORE) begin
            rec_buf_q[REC_W*count_q[3:0] +: REC_W] <= rec;
            count_q <= count_q + 5'd1;
            seq_q   <= seq_q + 1'b1;
         end else if (m_valid && m_ready) begin
            count_q   <= '0;
            rec_buf_q <= '0;
         end
         if (state_q == STORE) img_count <= img_count + 32'd1;
      end
   end
endmodule

// File: tb/tb_cl_sde_vgg_result_packer.sv
// tb_cl_sde_vgg_result_packer: directed self-checking bench for the result packer
module tb_cl_sde_vgg_result_packer;
   logic clk = 0, rst_n = 0, cfg_clear = 0, s_valid = 0, m_ready = 0;
   logic [15:0] cfg_flush_to = 0;
   logic [159:0] s_data = 0;
   logic s_ready, m_valid, m_last;
   logic [511:0] m_data;
   logic [63:0] m_keep, m_user;
   logic [31:0] img_count;
   int checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
   logic [511:0] beats[$];
   logic [63:0] users[$];
   cl_sde_vgg_result_packer dut (
      .clk(clk), .rst_n(rst_n), .cfg_flush_to(cfg_flush_to), .cfg_clear(cfg_clear),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .m_valid(m_valid),
      .m_data(m_data), .m_keep(m_keep), .m_user(m_user), .m_last(m_last),
      .m_ready(m_ready), .img_count(img_count)
   );
   always #5 clk = ~clk;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (m_valid && m_ready) begin
         beats.push_back(m_data);
         users.push_back(m_user);
      end
   end
   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [159:0] pk(input int v[10]);
      logic [159:0] r;
      for (int i = 0; i < 10; i++) r[i*16 +: 16] = 16'(v[i]);
      return r;
   endfunction
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send(input logic [159:0] d);
      int n = 0;
      s_valid = 1;
      s_data = d;
      while (!s_ready && n < 1000) begin
         tick(1);
         n++;
      end
      chk("send_rdy", s_ready, 1);
      tick(1);
      acc_cyc = cyc;
      s_valid = 0;
   endtask
   task automatic take_beat(input string tag, input int lat, input int stall,
                            input logic [511:0] d, input logic [63:0] k, input logic [63:0] u);
      int n = 0;
      logic bad = 0;
      while (!m_valid && n < 300) begin
         tick(1);
         n++;
      end
      chk({tag, "_valid"}, m_valid, 1);
      chk({tag, "_lat"}, cyc - acc_cyc, lat);
      chk({tag, "_data"}, m_data, d);
      chk({tag, "_keep"}, m_keep, k);
      chk({tag, "_user"}, m_user, u);
      chk({tag, "_last"}, m_last, 1);
      if (stall > 0) begin
         s_valid = 1;
         s_data = '1;
         for (int i = 0; i < stall; i++) begin
            tick(1);
            if (!m_valid || m_data !== d || m_keep !== k || s_ready) bad = 1;
         end
         s_valid = 0;
         chk({tag, "_stall"}, bad, 0);
      end
      m_ready = 1;
      tick(1);
      m_ready = 0;
      chk({tag, "_drop"}, m_valid, 0);
      chk({tag, "_srdy"}, s_ready, 1);
   endtask
   task automatic quiet(input string tag, input int n);
      logic seen = 0;
      for (int i = 0; i < n; i++) begin
         tick(1);
         if (m_valid) seen = 1;
      end
      chk(tag, seen, 0);
   endtask
   task automatic clear_pulse();
      cfg_clear = 1;
      tick(1);
      cfg_clear = 0;
   endtask
   int t1[10], t2[10], v[10];
   logic [159:0] d1, d2;
   logic [511:0] exp_d;
   int a0;
   initial begin
      t1 = '{5, -3, 7, 7, 2, 0, -8, 1, 6, 7};
      t2 = '{-100, -2, -50, -7, -9, -30, -4, -80, -3, -2};
      d1 = pk(t1);
      d2 = pk(t2);
      tick(3);
      chk("rst_srdy", s_ready, 1);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_mdata", m_data, 0);
      chk("rst_mkeep", m_keep, 0);
      chk("rst_muser", m_user, 0);
      chk("rst_imgcnt", img_count, 0);
      rst_n = 1;
      tick(1);
      // single image, tie resolved to lowest index, timeout flush after 20 idle cycles
      cfg_flush_to = 20;
      send(d1);
      take_beat("t1", 30, 0, 512'h0007_0002, 64'hF, 64'd1);
      // all-negative logits with a 50-cycle downstream stall
      send(d2);
      take_beat("t2", 30, 50, 512'hFFFE_0011, 64'hF, 64'd1);
      chk("t2_imgcnt", img_count, 2);
      // 16 back-to-back images fill one beat, no timeout
      cfg_flush_to = 0;
      clear_pulse();
      exp_d = '0;
      for (int k = 0; k < 16; k++) begin
         v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
         v[k % 10] = k + 1;
         exp_d[32*k +: 32] = {16'(k + 1), 12'(k), 4'(k % 10)};
         send(pk(v));
         if (k == 0) a0 = acc_cyc;
         if (k == 1) chk("t3_rate", acc_cyc - a0, 11);
      end
      take_beat("t3", 10, 0, exp_d, '1, 64'd16);
      // three images then idle-timeout partial flush
      cfg_flush_to = 8;
      for (int k = 0; k < 3; k++) send(d1);
      take_beat("t5", 18, 0, 512'h0007_0122_0007_0112_0007_0102, 64'hFFF, 64'd3);
      // clear during SCAN lands after STORE: record dropped, seq restarts at 0
      send(d1);
      tick(2);
      clear_pulse();
      quiet("t5_clr_quiet", 40);
      send(d2);
      take_beat("t5c", 18, 0, 512'hFFFE_0001, 64'hF, 64'd1);
      chk("t5_imgcnt", img_count, 23);
      // reset mid-SCAN
      send(d1);
      tick(3);
      rst_n = 0;
      tick(1);
      chk("rst2_srdy", s_ready, 1);
      chk("rst2_mvalid", m_valid, 0);
      chk("rst2_mkeep", m_keep, 0);
      chk("rst2_imgcnt", img_count, 0);
      rst_n = 1;
      quiet("rst2_quiet", 40);
      // 4100 images: sequence wraps, final partial beat flushed by timeout
      cfg_flush_to = 0;
      m_ready = 1;
      beats.delete();
      users.delete();
      for (int k = 0; k < 4100; k++) send(d1);
      tick(15);
      chk("t6_nbeats", beats.size(), 256);
      if (beats.size() >= 256) begin
         chk("t6_first", beats[0][31:0], 32'h0007_0002);
         chk("t6_wrapfff", beats[255][511:480], 32'h0007_FFF2);
         chk("t6_user", users[255], 64'd16);
      end
      chk("t6_imgcnt", img_count, 4100);
      cfg_flush_to = 8;
      for (int i = 0; i < 50 && beats.size() < 257; i++) tick(1);
      chk("t6_nbeats2", beats.size(), 257);
      if (beats.size() >= 257) begin
         chk("t6_tail", beats[256], 512'h0007_0032_0007_0022_0007_0012_0007_0002);
         chk("t6_tailuser", users[256], 64'd4);
      end
      m_ready = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
